eq_gain_ctrl: RTL and testbench
===============================

# eq_gain_ctrl

Sequences equalizer band-gain updates from the MCU into the audio filter bank. The block latches the 32-bit gain word when the SPI receiver finishes a transfer. It then ramps each band's applied gain one code per sample period toward the new target, which avoids zipper noise. It reports completion back to the SPI side through `done`. It sits between `eq_spi` (word source, `done` consumer) and the per-band filter datapath (gain consumer).

## Interface
- `NBANDS`, default 8: number of EQ bands.
- `GW`, default 4: gain code width per band; unity = 2^(GW-1) (8).
- `RAMP_DIV`, default 1: sample ticks per ramp step, must be ≥1.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `load` in 1: high while the MCU shifts a word in; the falling edge marks the word complete.
- `eqVals` in NBANDS*GW: gain word from the SPI shift register, stable while `load`=0. Band b occupies `[b*GW +: GW]`.
- `sample_tick` in 1: one-cycle strobe per audio sample.
- `gain` out NBANDS*GW: currently applied gains, same packing as `eqVals`.
- `gain_update` out 1: one-cycle pulse in the cycle `gain` first shows a new value.
- `busy` out 1: high while a target is captured but not yet reached.
- `done` out 1: high when idle and no transfer is in progress; drives the `done` input of `eq_spi`.

## Operation
- Registers:
  - `load_q`: `load` delayed one cycle.
  - `target[NBANDS*GW]`.
  - `gain`.
  - Divider counter `div_cnt`, wide enough for RAMP_DIV-1.
  - State.
- States:
  - IDLE: `gain`==`target`. On fall (`load_q`=1 and `load`=0) go to CAPTURE.
  - CAPTURE: one cycle.
    - `target<=eqVals`, `div_cnt<=0`.
    - If `eqVals`==`gain`, go to IDLE; otherwise go to RAMP.
  - RAMP: on each `sample_tick`:
    - If `div_cnt`==RAMP_DIV-1: `div_cnt<=0`, and every band steps ±1 toward its `target` band. Bands already equal do not move, and no band overshoots. Assert `gain_update` next cycle. If after the step all bands equal `target`, go to IDLE.
    - Otherwise `div_cnt<=div_cnt+1`.
    - Without `sample_tick`, `gain` holds and there is no timeout.
  - A fall detected in RAMP goes to CAPTURE; the latest word wins. The ramp then continues from the current `gain`, never from the old target.
- Outputs:
  - `busy` = (state≠IDLE).
  - `done` = (state==IDLE) && !`load_q`.
  - `gain_update` is registered.
- Arithmetic: per-band unsigned GW-bit compare and ±1 step; no carry between bands.
- Reset:
  - `gain`=`target`= unity in every band (32'h88888888 at defaults).
  - State IDLE, `div_cnt`=0, `load_q`=0, `gain_update`=0.
  - Therefore `busy`=0 and `done`=1.
  - Reset mid-ramp discards the pending target.

## Timing
- Fall detected at clock edge k → CAPTURE after edge k → `target` loaded at edge k+1.
- Equal word: IDLE after edge k+1; `done` high from that cycle; no `gain_update`.
- First step occurs at the first edge ≥k+2 that samples `sample_tick` with `div_cnt`==RAMP_DIV-1.
- Worst-case ramp is (2^GW − 1)·RAMP_DIV ticks (15 at defaults).
- `done` falls the cycle after `load` rises, since it is taken from `load_q`. `done` stays low throughout RAMP.
- Simultaneous events:
  - Fall detection and `sample_tick` in RAMP: capture wins, the tick is dropped and `div_cnt` cleared.
  - `reset` overrides everything.
- The last step and the return to IDLE occur at the same edge. `gain_update`, `done`=1 and `busy`=0 are visible together in the following cycle.

## Test plan
- Reset: assert `reset` 2 cycles → `gain`=32'h88888888, `done`=1, `busy`=0, `gain_update`=0.
- Up-ramp: load 32'h8888888C, then 4 `sample_tick`s spaced 10 cycles → band0 = 9, A, B, C, with exactly 4 `gain_update` pulses. `busy` high from CAPTURE to last step; `done`=1 after 4th step; other bands stay 8.
- Down-ramp with RAMP_DIV=3: load 32'h08888888 → band7 decrements once per 3 ticks, reaching 0 after 24 ticks. Gaps with no tick leave `gain` frozen and `busy`=1.
- Retarget: during the up-ramp, after band0 reaches A, load 32'h88888888 → next ticks give band0 9, then 8, then IDLE; no overshoot to B. A tick coinciding with fall detection produces no step.
- Equal word: load 32'h88888888 from reset → `done` low while `load` high, `done` high 2 cycles after the fall, no `gain_update`, `busy` high for exactly 1 cycle.
- Reset mid-ramp: start 32'hFFFFFFFF ramp, assert `reset` after 3 steps → next cycle `gain`=32'h88888888, `done`=1. Later ticks produce no change.

Source files
------------

// File: rtl/eq_gain_ctrl.sv
// Equalizer band-gain sequencer: captures a gain word when an SPI load ends and
// ramps every band one code per step toward it so the filter bank never sees a jump.
module eq_gain_ctrl #(
    parameter int NBANDS   = 8,
    parameter int GW       = 4,
    parameter int RAMP_DIV = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [NBANDS*GW-1:0]   eqVals,
    input  logic                   sample_tick,
    output logic [NBANDS*GW-1:0]   gain,
    output logic                   gain_update,
    output logic                   busy,
    output logic                   done
);

    // state   | meaning
    // IDLE    | gain equals target, waiting for the end of an SPI load
    // CAPTURE | latch the new word as target, decide whether a ramp is needed
    // RAMP    | step bands toward target on every RAMP_DIV-th sample tick

    localparam int W  = NBANDS * GW;
    localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [GW-1:0] UNITY    = GW'(1) << (GW - 1);
    localparam logic [GW-1:0] ONE      = GW'(1);
    localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        RAMP    = 2'd2
    } state_t;

    state_t          state;
    logic            load_q;
    logic [W-1:0]    target;
    logic [DW-1:0]   div_cnt;
    logic [W-1:0]    step_gain;
    logic            step_done;
    logic            fall;

    assign fall = load_q & ~load;

    // Per-band saturating step toward target; bands are independent, no carries.
    always_comb begin
        step_gain = gain;
        for (int b = 0; b < NBANDS; b++) begin
            if (gain[b*GW +: GW] < target[b*GW +: GW])
                step_gain[b*GW +: GW] = gain[b*GW +: GW] + ONE;
            else if (gain[b*GW +: GW] > target[b*GW +: GW])
                step_gain[b*GW +: GW] = gain[b*GW +: GW] - ONE;
        end
        step_done = (step_gain == target);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            load_q      <= 1'b0;
            target      <= {NBANDS{UNITY}};
            gain        <= {NBANDS{UNITY}};
            div_cnt     <= '0;
            gain_update <= 1'b0;
        end else begin
            load_q      <= load;
            gain_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    target  <= eqVals;
                    div_cnt <= '0;
                    state   <= (eqVals == gain) ? IDLE : RAMP;
                end
                RAMP: begin
                    // A new word takes priority; a coincident tick is dropped.
                    if (fall) begin
                        state   <= CAPTURE;
                        div_cnt <= '0;
                    end else if (sample_tick) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt     <= '0;
                            gain        <= step_gain;
                            gain_update <= 1'b1;
                            if (step_done)
                                state <= IDLE;
                        end else begin
                            div_cnt <= div_cnt + DIV_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == IDLE) && !load_q;

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Directed bench for eq_gain_ctrl: a default instance and a RAMP_DIV=3 instance,
// with expected gain words queued at each tick and checked on every gain_update.
module tb_eq_gain_ctrl;

    logic        clk;
    logic        reset;
    logic        load;
    logic [31:0] eqVals;
    logic        sample_tick;
    logic        sel3;

    logic        load_a, tick_a, load_b, tick_b;
    logic [31:0] gain_a, gain_b;
    logic        upd_a, upd_b, busy_a, busy_b, done_a, done_b;
    logic [31:0] cur_gain;
    logic        cur_busy, cur_done;

    int n_cmp = 0;
    int n_fail = 0;
    int upd_cnt_a = 0;
    int upd_cnt_b = 0;
    int base;
    logic [31:0] sb_a[$];
    logic [31:0] sb_b[$];
    logic [31:0] mdl_g, mdl_t;

    assign load_a = load & ~sel3;
    assign tick_a = sample_tick & ~sel3;
    assign load_b = load & sel3;
    assign tick_b = sample_tick & sel3;
    assign cur_gain = sel3 ? gain_b : gain_a;
    assign cur_busy = sel3 ? busy_b : busy_a;
    assign cur_done = sel3 ? done_b : done_a;

    eq_gain_ctrl dut (
        .clk(clk), .reset(reset), .load(load_a), .eqVals(eqVals),
        .sample_tick(tick_a), .gain(gain_a), .gain_update(upd_a),
        .busy(busy_a), .done(done_a)
    );

    eq_gain_ctrl #(.RAMP_DIV(3)) dut3 (
        .clk(clk), .reset(reset), .load(load_b), .eqVals(eqVals),
        .sample_tick(tick_b), .gain(gain_b), .gain_update(upd_b),
        .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mstep(input logic [31:0] g, input logic [31:0] t);
        logic [31:0] r;
        logic [3:0]  gb, tb;
        r = g;
        for (int b = 0; b < 8; b++) begin
            gb = g[b*4 +: 4];
            tb = t[b*4 +: 4];
            if (gb < tb)      r[b*4 +: 4] = gb + 4'd1;
            else if (gb > tb) r[b*4 +: 4] = gb - 4'd1;
        end
        return r;
    endfunction

    // Scoreboard pop on every applied-gain update.
    always @(negedge clk) begin
        if (upd_a) begin
            upd_cnt_a++;
            if (sb_a.size() > 0) chk("upd_gain", gain_a, sb_a.pop_front());
            else                 chk("upd_spurious", 32'(upd_a), 32'd0);
        end
        if (upd_b) begin
            upd_cnt_b++;
            if (sb_b.size() > 0) chk("upd_gain3", gain_b, sb_b.pop_front());
            else                 chk("upd_spurious3", 32'(upd_b), 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] w);
        if (sel3) sb_b.push_back(w);
        else      sb_a.push_back(w);
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        step(n);
        reset = 1'b0;
    endtask

    // Shift a word in, then drop load; returns just after the edge that sees the fall.
    task automatic load_word(input logic [31:0] w, input logic tick_at_fall);
        load   = 1'b1;
        eqVals = $urandom;
        step(1);
        chk("done_during_load", 32'(cur_done), 32'd0);
        step(2);
        eqVals      = w;
        load        = 1'b0;
        sample_tick = tick_at_fall;
        step(1);
        sample_tick = 1'b0;
        chk("busy_capture", 32'(cur_busy), 32'd1);
        chk("done_capture", 32'(cur_done), 32'd0);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; eqVals = '0; sample_tick = 1'b0; sel3 = 1'b0;

        // Reset state
        step(2);
        reset = 1'b0;
        chk("rst_gain", gain_a, 32'h88888888);
        chk("rst_done", 32'(done_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_upd", 32'(upd_a), 32'd0);
        chk("rst_gain3", gain_b, 32'h88888888);
        step(2);

        // Up-ramp band0 8 -> C, ticks spaced 10 cycles
        base  = upd_cnt_a;
        mdl_g = 32'h88888888;
        mdl_t = 32'h8888888C;
        load_word(mdl_t, 1'b0);
        step(1);
        chk("up_busy_ramp", 32'(busy_a), 32'd1);
        for (int i = 0; i < 4; i++) begin
            mdl_g = mstep(mdl_g, mdl_t);
            push(mdl_g);
            tick();
            chk("up_gain", gain_a, mdl_g);
            if (i < 3) begin
                chk("up_busy", 32'(busy_a), 32'd1);
                chk("up_done", 32'(done_a), 32'd0);
            end
            step(9);
            chk("up_hold", gain_a, mdl_g);
        end
        chk("up_final", gain_a, 32'h8888888C);
        chk("up_done_end", 32'(done_a), 32'd1);
        chk("up_busy_end", 32'(busy_a), 32'd0);
        chk("up_pulses", 32'(upd_cnt_a - base), 32'd4);

        // Retarget mid-ramp, tick coinciding with fall detection
        do_reset(2);
        base  = upd_cnt_a;
        mdl_g = 32'h88888888;
        mdl_t = 32'h8888888C;
        load_word(mdl_t, 1'b0);
        step(1);
        for (int i = 0; i < 2; i++) begin
            mdl_g = mstep(mdl_g, mdl_t);
            push(mdl_g);
            tick();
            step(2);
        end
        chk("rt_at_A", gain_a, 32'h8888888A);
        mdl_t = 32'h88888888;
        load_word(mdl_t, 1'b1);
        chk("rt_no_step", gain_a, 32'h8888888A);
        step(1);
        for (int i = 0; i < 2; i++) begin
            mdl_g = mstep(mdl_g, mdl_t);
            push(mdl_g);
            tick();
            chk("rt_gain", gain_a, mdl_g);
            step(2);
        end
        chk("rt_final", gain_a, 32'h88888888);
        chk("rt_done", 32'(done_a), 32'd1);
        tick();
        step(2);
        chk("rt_idle_tick", gain_a, 32'h88888888);
        chk("rt_pulses", 32'(upd_cnt_a - base), 32'd4);

        // Equal word from reset
        do_reset(2);
        base = upd_cnt_a;
        load_word(32'h88888888, 1'b0);
        step(1);
        chk("eq_busy", 32'(busy_a), 32'd0);
        chk("eq_done", 32'(done_a), 32'd1);
        step(3);
        chk("eq_gain", gain_a, 32'h88888888);
        chk("eq_no_upd", 32'(upd_cnt_a - base), 32'd0);

        // Down-ramp on the RAMP_DIV=3 instance, with a tick-free gap
        sel3  = 1'b1;
        base  = upd_cnt_b;
        mdl_g = 32'h88888888;
        mdl_t = 32'h08888888;
        load_word(mdl_t, 1'b0);
        step(1);
        for (int t = 1; t <= 24; t++) begin
            if (t % 3 == 0) begin
                mdl_g = mstep(mdl_g, mdl_t);
                push(mdl_g);
            end
            tick();
            chk("dn_gain", gain_b, mdl_g);
            if (t == 4) begin
                step(6);
                chk("dn_frozen", gain_b, mdl_g);
                chk("dn_busy_gap", 32'(busy_b), 32'd1);
            end
            step(1);
        end
        chk("dn_final", gain_b, 32'h08888888);
        chk("dn_done", 32'(done_b), 32'd1);
        chk("dn_pulses", 32'(upd_cnt_b - base), 32'd8);
        sel3 = 1'b0;
        step(2);

        // Reset mid-ramp discards the target
        do_reset(1);
        mdl_g = 32'h88888888;
        mdl_t = 32'hFFFFFFFF;
        load_word(mdl_t, 1'b0);
        step(1);
        for (int i = 0; i < 3; i++) begin
            mdl_g = mstep(mdl_g, mdl_t);
            push(mdl_g);
            tick();
            step(1);
        end
        chk("mr_before", gain_a, 32'hBBBBBBBB);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mr_gain", gain_a, 32'h88888888);
        chk("mr_done", 32'(done_a), 32'd1);
        chk("mr_busy", 32'(busy_a), 32'd0);
        base = upd_cnt_a;
        for (int i = 0; i < 4; i++) begin
            tick();
            step(1);
        end
        chk("mr_after", gain_a, 32'h88888888);
        chk("mr_no_upd", 32'(upd_cnt_a - base), 32'd0);

        step(3);
        chk("sb_empty", 32'(sb_a.size()), 32'd0);
        chk("sb3_empty", 32'(sb_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
